// File: rtl/axis_burst_memory.sv
// Purpose    : on-chip word memory with a strobed burst write stream and a burst read stream.
// Latency    : write beat lands in memory on its handshake edge; read tvalid two edges after rd_en.
// Backpressure: write side always ready inside a burst; read side holds tdata/tlast while tready=0.
//
// Ports
//   axis_aclk / axis_areset   clock, synchronous active-high reset
//   s02_axis_wr_en/wr_addr    start a write burst at wr_addr
//   s02_axis_t*               write beats (tdata, tstrb byte enables, tvalid, tlast, tready)
//   m02_axis_rd_en/addr/len   start a read burst of rd_len+1 beats at rd_addr
//   m02_axis_t*               read beats (tdata, tstrb, tvalid, tlast, tready)
//   wr_busy / rd_busy         write / read engine not idle
module axis_burst_memory #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                    axis_aclk,
   input  logic                    axis_areset,
   input  logic                    s02_axis_wr_en,
   input  logic [ADDR_WIDTH-1:0]   s02_axis_wr_addr,
   input  logic [DATA_WIDTH-1:0]   s02_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s02_axis_tstrb,
   input  logic                    s02_axis_tvalid,
   input  logic                    s02_axis_tlast,
   output logic                    s02_axis_tready,
   input  logic                    m02_axis_rd_en,
   input  logic [ADDR_WIDTH-1:0]   m02_axis_rd_addr,
   input  logic [LEN_WIDTH-1:0]    m02_axis_rd_len,
   output logic [DATA_WIDTH-1:0]   m02_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m02_axis_tstrb,
   output logic                    m02_axis_tvalid,
   output logic                    m02_axis_tlast,
   input  logic                    m02_axis_tready,
   output logic                    wr_busy,
   output logic                    rd_busy
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int DEPTH      = 1 << ADDR_WIDTH;

   typedef enum logic       {W_IDLE, W_BURST} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} r_state_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   w_state_t              w_state, w_state_nxt;
   r_state_t              r_state, r_state_nxt;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr_inc;
   logic [LEN_WIDTH-1:0]  remaining;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  w_start, w_beat;
   logic                  r_start, r_advance;

   assign rd_ptr_inc = rd_ptr + 1'b1;

   always_ff @(posedge axis_aclk) begin
      if (axis_areset) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
      end else begin
         w_state <= w_state_nxt;
         r_state <= r_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = w_state;
      s02_axis_tready = 1'b0;
      wr_busy         = 1'b0;
      w_start         = 1'b0;
      w_beat          = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (s02_axis_wr_en) begin
               w_start     = 1'b1;
               w_state_nxt = W_BURST;
            end
         end
         W_BURST: begin
            s02_axis_tready = 1'b1;
            wr_busy         = 1'b1;
            w_beat          = s02_axis_tvalid;
            if (s02_axis_tvalid && s02_axis_tlast)
               w_state_nxt = W_IDLE;
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_nxt     = r_state;
      m02_axis_tvalid = 1'b0;
      rd_busy         = 1'b0;
      r_start         = 1'b0;
      r_advance       = 1'b0;
      case (r_state)
         R_IDLE: begin
            if (m02_axis_rd_en) begin
               r_start     = 1'b1;
               r_state_nxt = R_FETCH;
            end
         end
         R_FETCH: begin
            rd_busy     = 1'b1;
            r_state_nxt = R_STREAM;
         end
         R_STREAM: begin
            rd_busy         = 1'b1;
            m02_axis_tvalid = 1'b1;
            if (m02_axis_tready) begin
               if (remaining == '0)
                  r_state_nxt = R_IDLE;
               else
                  r_advance = 1'b1;
            end
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   assign m02_axis_tlast = m02_axis_tvalid && (remaining == '0);
   assign m02_axis_tstrb = {STRB_WIDTH{m02_axis_tvalid}};
   assign m02_axis_tdata = rd_data;

   // Memory array has no reset; a beat presented during reset must not land.
   always_ff @(posedge axis_aclk) begin
      if (w_beat && !axis_areset) begin
         for (int i = 0; i < STRB_WIDTH; i++) begin
            if (s02_axis_tstrb[i])
               mem[wr_ptr][i*8 +: 8] <= s02_axis_tdata[i*8 +: 8];
         end
      end
   end

   // Read data register is loaded with the next word on the same edge as a
   // handshake so the stream runs one beat per cycle. Reads see the pre-edge
   // array contents, giving read-first behaviour on address collisions.
   always_ff @(posedge axis_aclk) begin
      if (axis_areset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         remaining <= '0;
         rd_data   <= '0;
      end else begin
         if (w_start)
            wr_ptr <= s02_axis_wr_addr;
         else if (w_beat)
            wr_ptr <= wr_ptr + 1'b1;

         if (r_start) begin
            rd_ptr    <= m02_axis_rd_addr;
            remaining <= m02_axis_rd_len;
         end else if (r_advance) begin
            rd_ptr    <= rd_ptr_inc;
            remaining <= remaining - 1'b1;
         end

         if (r_state == R_FETCH)
            rd_data <= mem[rd_ptr];
         else if (r_advance)
            rd_data <= mem[rd_ptr_inc];
      end
   end
endmodule

// File: tb/tb_axis_burst_memory.sv
module tb_axis_burst_memory;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int LW = 8;
   localparam int SW = DW / 8;

   logic          clk = 1'b0;
   logic          areset;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] s_tdata;
   logic [SW-1:0] s_tstrb;
   logic          s_tvalid, s_tlast, s_tready;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [LW-1:0] rd_len;
   logic [DW-1:0] m_tdata;
   logic [SW-1:0] m_tstrb;
   logic          m_tvalid, m_tlast, m_tready;
   logic          wr_busy, rd_busy;

   int checks   = 0;
   int failures = 0;

   // Reference model: word image plus per-byte "has been written" flags.
   logic [DW-1:0] shadow [1<<AW];
   logic [SW-1:0] sbv    [1<<AW];
   logic [DW-1:0] wdat   [16];
   logic [SW-1:0] wstrb  [16];
   logic [DW-1:0] rx_q   [$];

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [SW-1:0] strb;
      logic [DW-1:0] exp;
   } vec_t;
   vec_t vt [6];

   always #5 clk = ~clk;

   axis_burst_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .axis_aclk        (clk),
      .axis_areset      (areset),
      .s02_axis_wr_en   (wr_en),
      .s02_axis_wr_addr (wr_addr),
      .s02_axis_tdata   (s_tdata),
      .s02_axis_tstrb   (s_tstrb),
      .s02_axis_tvalid  (s_tvalid),
      .s02_axis_tlast   (s_tlast),
      .s02_axis_tready  (s_tready),
      .m02_axis_rd_en   (rd_en),
      .m02_axis_rd_addr (rd_addr),
      .m02_axis_rd_len  (rd_len),
      .m02_axis_tdata   (m_tdata),
      .m02_axis_tstrb   (m_tstrb),
      .m02_axis_tvalid  (m_tvalid),
      .m02_axis_tlast   (m_tlast),
      .m02_axis_tready  (m_tready),
      .wr_busy          (wr_busy),
      .rd_busy          (rd_busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                       input logic [SW-1:0] s);
      for (int b = 0; b < SW; b++) begin
         if (s[b]) begin
            shadow[a][b*8 +: 8] = d[b*8 +: 8];
            sbv[a][b]           = 1'b1;
         end
      end
   endfunction

   function automatic logic [DW-1:0] bmask(input logic [SW-1:0] v);
      logic [DW-1:0] m;
      m = '0;
      for (int b = 0; b < SW; b++)
         if (v[b]) m[b*8 +: 8] = 8'hFF;
      return m;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_s_tready"}, s_tready, 0);
      chk({tag, "_m_tvalid"}, m_tvalid, 0);
      chk({tag, "_m_tlast"},  m_tlast,  0);
      chk({tag, "_m_tstrb"},  m_tstrb,  0);
      chk({tag, "_m_tdata"},  m_tdata,  0);
      chk({tag, "_wr_busy"},  wr_busy,  0);
      chk({tag, "_rd_busy"},  rd_busy,  0);
   endtask

   // Write n beats from wdat/wstrb starting at addr; optional idle gaps with junk data.
   task automatic write_burst(input logic [AW-1:0] addr, input int n, input bit gaps);
      wr_addr = addr;
      wr_en   = 1'b1;
      tick();
      wr_en = 1'b0;
      chk("wr_tready_up", s_tready, 1);
      chk("wr_busy_up", wr_busy, 1);
      for (int k = 0; k < n; k++) begin
         if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
               s_tvalid = 1'b0;
               s_tdata  = $urandom;
               s_tstrb  = 4'hF;
               s_tlast  = 1'b1;
               tick();
            end
         end
         s_tvalid = 1'b1;
         s_tdata  = wdat[k];
         s_tstrb  = wstrb[k];
         s_tlast  = (k == n - 1);
         model_write(AW'(addr + k), wdat[k], wstrb[k]);
         tick();
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      chk("wr_tready_end", s_tready, 0);
      chk("wr_busy_end", wr_busy, 0);
   endtask

   // mode 0: always ready, 1: ready 1,0,1,0..., 2: random ready.
   task automatic read_burst(input logic [AW-1:0] addr, input logic [LW-1:0] len, input int mode);
      int            beats;
      int            cyc;
      bit            stalled;
      logic [DW-1:0] prev;
      logic [DW-1:0] m;
      logic [AW-1:0] a;
      beats   = 0;
      cyc     = 0;
      stalled = 0;
      prev    = '0;
      rx_q.delete();
      rd_addr  = addr;
      rd_len   = len;
      rd_en    = 1'b1;
      m_tready = 1'b0;
      tick();
      rd_en = 1'b0;
      chk("rd_lat_fetch", m_tvalid, 0);
      chk("rd_busy_up", rd_busy, 1);
      tick();
      chk("rd_lat_valid", m_tvalid, 1);
      while (beats <= int'(len) && cyc < 200) begin
         case (mode)
            0:       m_tready = 1'b1;
            1:       m_tready = (cyc % 2 == 0);
            default: m_tready = 1'($urandom_range(0, 1));
         endcase
         chk("rd_valid", m_tvalid, 1);
         if (stalled) chk("rd_hold_data", m_tdata, prev);
         if (m_tready) begin
            a = AW'(addr + beats);
            m = bmask(sbv[a]);
            if (m != '0) chk("rd_data", m_tdata & m, shadow[a] & m);
            chk("rd_tlast", m_tlast, (beats == int'(len)));
            chk("rd_tstrb", m_tstrb, 4'hF);
            rx_q.push_back(m_tdata);
            beats++;
            stalled = 0;
         end else begin
            stalled = 1;
            prev    = m_tdata;
         end
         tick();
         cyc++;
      end
      m_tready = 1'b0;
      if (beats <= int'(len)) begin
         checks++;
         failures++;
         $display("FAIL rd_timeout actual=%0d beats required=%0d", beats, int'(len) + 1);
      end
      chk("rd_done_valid", m_tvalid, 0);
      chk("rd_done_busy", rd_busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++) sbv[i] = '0;
      areset = 1'b1; wr_en = 1'b0; wr_addr = '0; s_tdata = '0; s_tstrb = '0;
      s_tvalid = 1'b0; s_tlast = 1'b0; rd_en = 1'b0; rd_addr = '0; rd_len = '0; m_tready = 1'b0;
      tick();
      tick();
      chk_all_zero("por");
      areset = 1'b0;
      tick();

      // Basic three-beat burst write then read back.
      wdat[0] = 32'h22; wdat[1] = 32'h33; wdat[2] = 32'h44;
      for (int k = 0; k < 3; k++) wstrb[k] = 4'hF;
      write_burst(12'h001, 3, 0);
      read_burst(12'h001, 2, 0);
      chk("t2_beat0", rx_q[0], 32'h22);
      chk("t2_beat1", rx_q[1], 32'h33);
      chk("t2_beat2", rx_q[2], 32'h44);

      // Byte-strobe merge table: single-beat write, single-beat read.
      vt[0] = '{12'h010, 32'hAABBCCDD, 4'hF, 32'hAABBCCDD};
      vt[1] = '{12'h010, 32'h11223344, 4'h5, 32'hAA22CC44};
      vt[2] = '{12'h010, 32'h55667788, 4'hA, 32'h55227744};
      vt[3] = '{12'h010, 32'h00000000, 4'h0, 32'h55227744};
      vt[4] = '{12'h7FF, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
      vt[5] = '{12'h7FF, 32'h12000000, 4'h8, 32'h12ADBEEF};
      for (int i = 0; i < 6; i++) begin
         wdat[0]  = vt[i].data;
         wstrb[0] = vt[i].strb;
         write_burst(vt[i].addr, 1, 0);
         read_burst(vt[i].addr, 0, 0);
         chk($sformatf("vec%0d", i), rx_q[0], vt[i].exp);
      end

      // Alternating tready over a four-beat read.
      for (int k = 0; k < 4; k++) begin
         wdat[k]  = 32'hC0DE0000 + k;
         wstrb[k] = 4'hF;
      end
      write_burst(12'h040, 4, 0);
      read_burst(12'h040, 3, 1);
      for (int k = 0; k < 4; k++)
         chk($sformatf("t4_beat%0d", k), rx_q[k], 32'hC0DE0000 + k);

      // Address wrap at the top of memory.
      wdat[0] = 32'hF00DFFFF; wdat[1] = 32'hF00D0000;
      write_burst(12'hFFF, 2, 0);
      read_burst(12'hFFF, 1, 0);
      chk("t5_top", rx_q[0], 32'hF00DFFFF);
      chk("t5_wrap", rx_q[1], 32'hF00D0000);
      read_burst(12'h000, 0, 0);
      chk("t5_zero", rx_q[0], 32'hF00D0000);

      // Reset in the middle of a write burst and a read burst.
      wdat[0] = 32'h5A5A5A5A; wstrb[0] = 4'hF;
      write_burst(12'h101, 1, 0);
      wr_addr = 12'h100; wr_en = 1'b1;
      rd_addr = 12'h010; rd_len = 3; rd_en = 1'b1;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      s_tvalid = 1'b1; s_tdata = 32'h0BADF00D; s_tstrb = 4'hF; s_tlast = 1'b0;
      model_write(12'h100, 32'h0BADF00D, 4'hF);
      tick();
      s_tdata = 32'hFFFFFFFF;
      areset = 1'b1;
      tick();
      chk_all_zero("rst1");
      tick();
      chk_all_zero("rst2");
      areset = 1'b0;
      s_tvalid = 1'b0;
      tick();
      read_burst(12'h100, 1, 0);
      chk("rst_keep0", rx_q[0], 32'h0BADF00D);
      chk("rst_keep1", rx_q[1], 32'h5A5A5A5A);

      // Reset right after the first read handshake.
      rd_addr = 12'h001; rd_len = 2; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      tick();
      m_tready = 1'b1;
      tick();
      m_tready = 1'b0;
      areset = 1'b1;
      tick();
      chk("t6_valid", m_tvalid, 0);
      chk("t6_busy", rd_busy, 0);
      areset = 1'b0;
      tick();
      read_burst(12'h001, 2, 0);
      chk("t6_beat0", rx_q[0], 32'h22);
      chk("t6_beat2", rx_q[2], 32'h44);

      // Same-edge write and fetch of one address returns the old word.
      wdat[0] = 32'h01010101; wstrb[0] = 4'hF;
      write_burst(12'h200, 1, 0);
      wr_addr = 12'h200; wr_en = 1'b1;
      rd_addr = 12'h200; rd_len = 0; rd_en = 1'b1;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      s_tvalid = 1'b1; s_tdata = 32'h02020202; s_tstrb = 4'hF; s_tlast = 1'b1;
      tick();
      s_tvalid = 1'b0; s_tlast = 1'b0;
      chk("coll_valid", m_tvalid, 1);
      chk("coll_old", m_tdata, 32'h01010101);
      m_tready = 1'b1;
      tick();
      m_tready = 1'b0;
      chk("coll_done", m_tvalid, 0);
      model_write(12'h200, 32'h02020202, 4'hF);
      read_burst(12'h200, 0, 0);
      chk("coll_new", rx_q[0], 32'h02020202);

      // Randomized bursts against the reference model.
      for (int it = 0; it < 30; it++) begin
         logic [AW-1:0] ra;
         int            rn;
         ra = AW'($urandom_range(0, (1 << AW) - 1));
         rn = $urandom_range(1, 8);
         for (int k = 0; k < rn; k++) begin
            wdat[k]  = $urandom;
            wstrb[k] = SW'($urandom_range(0, 15));
         end
         write_burst(ra, rn, 1);
         read_burst(ra, LW'(rn - 1), 2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
